// File: rtl/nfc_spi_pkg.sv
// nfc_spi_ctrl shared definitions.
// Register offsets, CTRL bit positions, FSM states.
package nfc_spi_pkg;

  localparam logic [4:0] ADDR_CTRL     = 5'h00;
  localparam logic [4:0] ADDR_DIV      = 5'h01;
  localparam logic [4:0] ADDR_BUF_BASE = 5'h10;

  // CTRL write fields
  localparam int CTRL_START    = 0;
  localparam int CTRL_DONE_CLR = 1;
  localparam int CTRL_IRQ_EN   = 2;
  localparam int CTRL_LEN_LSB  = 8;

  // CTRL read fields
  localparam int CTRL_BUSY = 0;
  localparam int CTRL_DONE = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SHIFT,
    ST_NEXT,
    ST_TRAIL
  } state_e;

  function automatic logic is_buf(
    input logic [4:0] a
  );
    return a[4] == ADDR_BUF_BASE[4];
  endfunction

endpackage

// File: rtl/nfc_spi_shifter.sv
// SPI mode-0 bit engine: half-period timer,
// bit counter, shift register, miso capture.
module nfc_spi_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] div_i,
  input  logic       act_i,
  input  logic       run_i,
  input  logic       byte_start_i,
  input  logic [7:0] tx_byte_i,
  input  logic       miso_i,
  output logic       sck_o,
  output logic       mosi_o,
  output logic       ph_end_o,
  output logic       byte_done_o,
  output logic [7:0] rx_byte_o
);

  logic [7:0] hcnt_q, hcnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sr_q, sr_d;
  logic [7:0] rx_q, rx_d;
  logic       sck_q, sck_d;
  logic       ph_end, rise, fall;

  assign ph_end = act_i && (hcnt_q == div_i);
  assign rise   = run_i && ph_end && !sck_q;
  assign fall   = run_i && ph_end && sck_q;

  assign ph_end_o    = ph_end;
  assign byte_done_o = fall && (bit_q == 3'd7);
  assign sck_o       = sck_q;
  assign mosi_o      = sr_q[7];
  assign rx_byte_o   = rx_q;

  // Phase timing; the next byte is preloaded on the
  // last falling edge so mosi is valid a full phase.
  always_comb begin
    hcnt_d = hcnt_q;
    bit_d  = bit_q;
    sr_d   = sr_q;
    rx_d   = rx_q;
    sck_d  = sck_q;
    if (byte_start_i) begin
      hcnt_d = 8'd0;
      bit_d  = 3'd0;
      sck_d  = 1'b0;
      sr_d   = tx_byte_i;
    end else if (act_i) begin
      hcnt_d = ph_end ? 8'd0 : hcnt_q + 8'd1;
      if (rise) begin
        sck_d = 1'b1;
        rx_d  = {rx_q[6:0], miso_i};
      end
      if (fall) begin
        sck_d = 1'b0;
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          sr_d = tx_byte_i;
        end else begin
          sr_d = {sr_q[6:0], 1'b0};
        end
      end
    end else begin
      hcnt_d = 8'd0;
      sck_d  = 1'b0;
    end
  end

  // Engine state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q <= 8'd0;
      bit_q  <= 3'd0;
      sr_q   <= 8'd0;
      rx_q   <= 8'd0;
      sck_q  <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      bit_q  <= bit_d;
      sr_q   <= sr_d;
      rx_q   <= rx_d;
      sck_q  <= sck_d;
    end
  end

endmodule

// File: rtl/nfc_spi_ctrl.sv
// Register-mapped SPI master for the NFC reader:
// registers, TX/RX buffers, sequencing FSM.
module nfc_spi_ctrl
  import nfc_spi_pkg::*;
#(
  parameter int DIV_RESET = 3,
  parameter int BUF_DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wr,
  input  logic        rd,
  input  logic [4:0]  addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        nfc_nss,
  output logic        nfc_sck,
  output logic        nfc_mosi,
  input  logic        nfc_miso,
  output logic        irq
);

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  idx_q, idx_d;
  logic        done_q, done_d;
  logic        irq_en_q, irq_en_d;
  logic [15:0] data_out_q, rdata;

  logic [7:0]  tx_mem [BUF_DEPTH];
  logic [7:0]  rx_mem [BUF_DEPTH];

  logic        busy, last;
  logic        ctrl_wr, div_wr, buf_wr;
  logic        start_acc, done_set, rx_we;
  logic        act, run, byte_start;
  logic        ph_end, byte_done;
  logic [3:0]  tx_sel;
  logic [7:0]  rx_byte;
  logic        unused_bits;

  assign busy      = state_q != ST_IDLE;
  assign last      = idx_q == len_q;
  assign ctrl_wr   = wr && (addr == ADDR_CTRL);
  assign div_wr    = wr && (addr == ADDR_DIV) && !busy;
  assign buf_wr    = wr && is_buf(addr) && !busy;
  assign start_acc = ctrl_wr && data_in[CTRL_START] && !busy;
  assign tx_sel    = busy ? idx_q + 4'd1 : 4'd0;

  assign nfc_nss     = !busy;
  assign irq         = done_q && irq_en_q;
  assign data_out    = data_out_q;
  assign unused_bits = ^data_in[15:12];

  nfc_spi_shifter u_shifter (
    .clk          (clk),
    .rst          (resetn),
    .div_i        (div_q),
    .act_i        (act),
    .run_i        (run),
    .byte_start_i (byte_start),
    .tx_byte_i    (tx_mem[tx_sel]),
    .miso_i       (nfc_miso),
    .sck_o        (nfc_sck),
    .mosi_o       (nfc_mosi),
    .ph_end_o     (ph_end),
    .byte_done_o  (byte_done),
    .rx_byte_o    (rx_byte)
  );

  // Transfer sequencing; NEXT doubles as the first
  // low cycle of the following byte or of TRAIL.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    act        = 1'b0;
    run        = 1'b0;
    byte_start = 1'b0;
    done_set   = 1'b0;
    rx_we      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          state_d    = ST_LEAD;
          byte_start = 1'b1;
          idx_d      = 4'd0;
        end
      end
      ST_LEAD: begin
        act = 1'b1;
        if (ph_end) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        act = 1'b1;
        run = 1'b1;
        if (byte_done) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        act   = 1'b1;
        run   = !last;
        rx_we = 1'b1;
        idx_d = idx_q + 4'd1;
        if (!last) begin
          state_d = ST_SHIFT;
        end else if (ph_end) begin
          state_d  = ST_IDLE;
          done_set = 1'b1;
        end else begin
          state_d = ST_TRAIL;
        end
      end
      ST_TRAIL: begin
        act = 1'b1;
        if (ph_end) begin
          state_d  = ST_IDLE;
          done_set = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register file next state; config frozen while busy.
  always_comb begin
    div_d    = div_q;
    len_d    = len_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;
    if (div_wr) div_d = data_in[7:0];
    if (ctrl_wr) begin
      irq_en_d = data_in[CTRL_IRQ_EN];
      if (!busy) len_d = data_in[CTRL_LEN_LSB +: 4];
    end
    if (done_set) begin
      done_d = 1'b1;
    end else if (start_acc) begin
      done_d = 1'b0;
    end else if (ctrl_wr && data_in[CTRL_DONE_CLR]) begin
      done_d = 1'b0;
    end
  end

  // Read mux.
  always_comb begin
    rdata = 16'd0;
    unique case (1'b1)
      addr == ADDR_CTRL: begin
        rdata[CTRL_BUSY]           = busy;
        rdata[CTRL_DONE]           = done_q;
        rdata[CTRL_IRQ_EN]         = irq_en_q;
        rdata[CTRL_LEN_LSB +: 4]   = len_q;
      end
      addr == ADDR_DIV: rdata[7:0] = div_q;
      is_buf(addr): rdata[7:0]     = rx_mem[addr[3:0]];
      default: rdata = 16'd0;
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q    <= ST_IDLE;
      div_q      <= 8'(DIV_RESET);
      len_q      <= 4'd0;
      idx_q      <= 4'd0;
      done_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      data_out_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      irq_en_q <= irq_en_d;
      if (rd) data_out_q <= rdata;
    end
  end

  // Byte buffers, not reset.
  always_ff @(posedge clk) begin
    if (buf_wr) tx_mem[addr[3:0]] <= data_in[7:0];
    if (rx_we) rx_mem[idx_q] <= rx_byte;
  end

endmodule

// File: tb/tb_nfc_spi_ctrl.sv
// Bench for nfc_spi_ctrl: transfer-level timeline
// model checked every cycle, plus directed reads.
module tb_nfc_spi_ctrl;

  logic        clk = 1'b0;
  logic        resetn, wr, rd;
  logic [4:0]  addr;
  logic [15:0] data_in, data_out;
  logic        nfc_nss, nfc_sck, nfc_mosi, nfc_miso, irq;

  always #5 clk = ~clk;

  nfc_spi_ctrl dut (
    .clk      (clk),
    .resetn   (resetn),
    .wr       (wr),
    .rd       (rd),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .nfc_nss  (nfc_nss),
    .nfc_sck  (nfc_sck),
    .nfc_mosi (nfc_mosi),
    .nfc_miso (nfc_miso),
    .irq      (irq)
  );

  int vec = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] m_tx [16];
  logic [7:0] m_rx [16];
  logic [7:0] m_div;
  logic [3:0] m_len;
  logic       m_irq_en, m_done, m_active;
  int         m_t0, m_h, m_l, m_total;
  logic       xfer_ok, loop_mode, miso_pat, chk_en;
  int         nss_lo, sck_rise;
  logic       sck_prev;

  assign nfc_miso = loop_mode ? nfc_mosi : miso_pat;

  task automatic check(input string nm,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h",
               nm, got, exp);
    end
  endtask

  function automatic logic pat_bit(input int g);
    logic [15:0] p;
    p = 16'h2AAA;
    return p[15 - (g % 16)];
  endfunction

  function automatic logic [15:0] model_rd(
    input logic [4:0] a);
    logic [15:0] v;
    v = 16'd0;
    if (a == 5'h00)
      v = {4'd0, m_len, 5'd0, m_irq_en, m_done, m_active};
    else if (a == 5'h01)
      v = {8'd0, m_div};
    else if (a[4])
      v = {8'd0, m_rx[a[3:0]]};
    return v;
  endfunction

  // Per-cycle compare against the transfer timeline.
  always @(negedge clk) begin : cmp
    int t, u, g;
    logic w, se, me;
    t = cyc - m_t0;
    if (m_active && t >= m_total) begin
      m_active = 1'b0;
      m_done   = 1'b1;
      if (xfer_ok) begin
        for (int b = 0; b < m_l; b++)
          for (int k = 0; k < 8; k++)
            m_rx[b][7-k] = loop_mode ? m_tx[b][7-k]
                                     : pat_bit(8*b + k);
      end
    end
    w  = m_active && t >= m_h &&
         t < m_h + 16*m_h*m_l;
    se = 1'b0;
    me = 1'b0;
    miso_pat = 1'b0;
    if (w) begin
      u  = t - m_h;
      g  = u / (2*m_h);
      se = (u % (2*m_h)) >= m_h;
      me = m_tx[g/8][7 - (g%8)];
      miso_pat = pat_bit(g);
    end
    if (!nfc_nss) nss_lo++;
    if (nfc_sck && !sck_prev) sck_rise++;
    sck_prev = nfc_sck;
    if (chk_en) begin
      check("nss", nfc_nss, !m_active);
      check("sck", nfc_sck, se);
      check("irq", irq, m_done && m_irq_en);
      if (w) check("mosi", nfc_mosi, me);
      if (resetn) check("mosi_rst", nfc_mosi, 1'b0);
    end
  end

  task automatic bus_wr(input logic [4:0] a,
                        input logic [15:0] d);
    @(negedge clk); #1;
    if (a == 5'h00) begin
      m_irq_en = d[2];
      if (!m_active) m_len = d[11:8];
      if (d[0] && !m_active) begin
        m_done   = 1'b0;
        m_h      = int'(m_div) + 1;
        m_l      = int'(m_len) + 1;
        m_total  = m_h * (2 + 16*m_l);
        m_t0     = cyc + 1;
        m_active = 1'b1;
        xfer_ok  = 1'b1;
        nss_lo   = 0;
        sck_rise = 0;
      end else if (d[1]) begin
        m_done = 1'b0;
      end
    end
    if (a == 5'h01 && !m_active) m_div = d[7:0];
    if (a[4] && !m_active) m_tx[a[3:0]] = d[7:0];
    wr = 1'b1; addr = a; data_in = d;
    @(negedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [4:0] a,
                        input string nm,
                        output logic [15:0] got);
    logic [15:0] e;
    @(negedge clk); #1;
    e  = model_rd(a);
    rd = 1'b1; addr = a;
    @(negedge clk);
    got = data_out;
    check(nm, data_out, e);
    #1 rd = 1'b0;
    @(negedge clk);
    check({nm, "_hold"}, data_out, e);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (m_active && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (m_active) begin
      vec++; bad++;
      $display("FAIL wait_idle: still busy after %0d", n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk); #1;
    resetn   = 1'b1;
    m_active = 1'b0;
    m_done   = 1'b0;
    m_div    = 8'd3;
    m_len    = 4'd0;
    m_irq_en = 1'b0;
    xfer_ok  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dout", data_out, 16'h0000);
    #1 resetn = 1'b0;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: run did not end");
    bad++;
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, bad);
    $finish;
  end

  initial begin : main
    logic [15:0] v;
    resetn = 1'b1; wr = 1'b0; rd = 1'b0;
    addr = 5'd0; data_in = 16'd0;
    loop_mode = 1'b0; miso_pat = 1'b0;
    m_div = 8'd3; m_len = 4'd0; m_irq_en = 1'b0;
    m_done = 1'b0; m_active = 1'b0; xfer_ok = 1'b0;
    m_t0 = 0; m_h = 1; m_l = 1; m_total = 0;
    nss_lo = 0; sck_rise = 0; sck_prev = 1'b0;
    chk_en = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_nss", nfc_nss, 1'b1);
    check("rst_sck", nfc_sck, 1'b0);
    check("rst_mosi", nfc_mosi, 1'b0);
    check("rst_irq", irq, 1'b0);
    check("rst_dout0", data_out, 16'h0000);
    #1 resetn = 1'b0;
    chk_en = 1'b1;

    bus_rd(5'h00, "ctrl_rst", v);
    check("ctrl_rst_lit", v, 16'h0000);
    bus_rd(5'h01, "div_rst", v);
    check("div_rst_lit", v, 16'h0003);

    // 16 bytes, DIV=0, patterned miso
    for (int i = 0; i < 16; i++)
      bus_wr(5'h10 + 5'(i), 16'(i * 8'h11));
    bus_wr(5'h01, 16'h0000);
    bus_wr(5'h00, 16'h0F01);
    wait_idle(2000);
    check("nss_lo_16", 16'(nss_lo), 16'd258);
    check("sck_edges_16", 16'(sck_rise), 16'd128);
    for (int i = 0; i < 16; i++)
      bus_rd(5'h10 + 5'(i), "rx16", v);
    bus_rd(5'h10, "rx0", v);
    check("rx0_lit", v, 16'h002A);
    bus_rd(5'h11, "rx1", v);
    check("rx1_lit", v, 16'h00AA);
    bus_rd(5'h00, "ctrl_16", v);

    // START rewritten mid-transfer is ignored
    bus_wr(5'h01, 16'h0002);
    bus_wr(5'h00, 16'h0201);
    repeat (40) @(negedge clk);
    bus_wr(5'h00, 16'h0501);
    bus_wr(5'h01, 16'h0000);
    wait_idle(2000);
    check("nss_lo_ign", 16'(nss_lo), 16'd150);
    check("sck_edges_ign", 16'(sck_rise), 16'd24);
    bus_rd(5'h00, "ctrl_ign", v);
    check("ctrl_ign_lit", v, 16'h0202);
    bus_rd(5'h01, "div_ign", v);
    check("div_ign_lit", v, 16'h0002);

    // reset during byte 3 of 8
    bus_wr(5'h01, 16'h0001);
    bus_wr(5'h00, 16'h0701);
    repeat (104) @(negedge clk);
    pulse_reset();
    repeat (2) @(negedge clk);
    bus_rd(5'h00, "ctrl_arst", v);
    check("ctrl_arst_lit", v, 16'h0000);
    bus_rd(5'h01, "div_arst", v);
    check("div_arst_lit", v, 16'h0003);

    // loopback, DIV=3, one byte, IRQ enabled
    loop_mode = 1'b1;
    bus_wr(5'h10, 16'h00A5);
    bus_wr(5'h00, 16'h0005);
    wait_idle(2000);
    check("nss_lo_lb", 16'(nss_lo), 16'd72);
    check("sck_edges_lb", 16'(sck_rise), 16'd8);
    check("irq_set", irq, 1'b1);
    bus_rd(5'h00, "ctrl_lb", v);
    check("ctrl_lb_lit", v, 16'h0006);
    bus_rd(5'h10, "rx_lb", v);
    check("rx_lb_lit", v, 16'h00A5);
    bus_rd(5'h05, "unmapped", v);
    check("unmapped_lit", v, 16'h0000);

    // START with DONE_CLR: START wins, irq drops
    bus_wr(5'h00, 16'h0007);
    check("irq_start", irq, 1'b0);
    wait_idle(2000);
    check("irq_set2", irq, 1'b1);
    bus_wr(5'h00, 16'h0006);
    check("irq_clr", irq, 1'b0);
    bus_rd(5'h00, "ctrl_clr", v);
    check("ctrl_clr_lit", v, 16'h0004);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, bad);
    $finish;
  end

endmodule

// File: doc/nfc_spi_ctrl.md
# nfc_spi_ctrl

Register-mapped SPI master controller that sequences transactions to the NFC reader chip. The host loads up to 16 bytes through the internal SPI-slave bus, then starts a transfer. The block drives nfc_nss/nfc_sck/nfc_mosi, captures nfc_miso into a receive buffer, and flags completion. It occupies one peripheral slot on the internal bus alongside the GPIO, UART and mic-array blocks.

## Interface
Parameters:
- DIV_RESET, 3: reset value of the DIV register; SCK half-period H = DIV+1 clk cycles.
- BUF_DEPTH, 16: TX/RX buffer depth in bytes; fixed at 16 for this revision.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-high reset (the name follows the codebase; asserted = 1).
- wr  in  1  bus write strobe, one cycle.
- rd  in  1  bus read strobe, one cycle.
- addr  in  5  register offset.
- data_in  in  16  write data.
- data_out  out  16  read data, registered.
- nfc_nss  out  1  chip select, active low.
- nfc_sck  out  1  SPI clock, mode 0 (idle low).
- nfc_mosi  out  1  serial data out, MSB first.
- nfc_miso  in  1  serial data in.
- irq  out  1  done & IRQ_EN.

## Operation
- Register map:
  - 0x00 CTRL. Write: bit0 START, bit1 DONE_CLR, bit2 IRQ_EN, bits[11:8] LEN (bytes = LEN+1). Read: bit0 BUSY, bit1 DONE, bit2 IRQ_EN, bits[11:8] LEN.
  - 0x01 DIV[7:0].
  - 0x10–0x1F: write = TX byte (data_in[7:0]); read = RX byte in [7:0], zeros above.
- FSM states:
  - IDLE -> LEAD on START.
  - LEAD waits H cycles, then -> SHIFT.
  - SHIFT runs 8 bits per byte. Each bit: H cycles with sck=0 and mosi valid, then H cycles with sck=1. nfc_miso is sampled on the clk where sck rises.
  - After 8 bits -> NEXT.
  - NEXT lasts one cycle: the RX byte is stored and the index increments. If index==LEN+1 -> TRAIL; otherwise -> SHIFT. The NEXT cycle is absorbed into the first low phase of the next byte, so sck timing stays uniform.
  - TRAIL holds sck=0 and nss=0 for H cycles, then -> IDLE. On that transition nss=1, BUSY=0 and DONE=1.
- START while BUSY is ignored.
- START clears DONE. DONE_CLR clears DONE. If START and DONE_CLR are written together, START wins and DONE ends at 0.
- TX-buffer writes and DIV/LEN writes while BUSY are ignored. LEN and DIV are latched at START. RX reads while BUSY return the current contents.
- Reads of unmapped offsets return 0.

## Timing
- Reset values:
  - nfc_nss=1, nfc_sck=0, nfc_mosi=0, data_out=0, irq=0.
  - DONE=0, BUSY=0, IRQ_EN=0, LEN=0, DIV=DIV_RESET.
  - State IDLE. Buffers are not reset.
- Write of START in cycle N: nfc_nss=0 and BUSY=1 from N+1.
- nss low duration is exactly H·(2+16·L) cycles, where L = LEN+1. Example: DIV=3, L=1 gives 72 cycles.
- mosi changes only while sck=0. It is valid at least H cycles before each rising edge.
- Read latency is 1 cycle: rd in cycle N gives data_out valid in N+1. data_out holds its value until the next rd.
- DIV=0 (H=1): sck toggles every cycle; this is legal.
- Reset asserted mid-transfer: outputs return to reset values immediately (asynchronously), with no partial DONE.

## Structure
- Package nfc_spi_pkg holds:
  - register offsets (CTRL=0x00, DIV=0x01, BUF_BASE=0x10);
  - CTRL bit positions;
  - FSM state enum {IDLE, LEAD, SHIFT, NEXT, TRAIL}.
- Sub-module nfc_spi_shifter contains the half-period counter, bit counter, 8-bit shift register, and sck/mosi generation plus miso sampling. It exposes byte_start, byte_done and rx_byte.
- The top level holds the register file, buffers, FSM and read mux.

## Test plan
- Loopback (miso=mosi), DIV=3, LEN=0, TX[0]=0xA5, START: 8 sck rising edges, nss low 72 cycles, RX[0]=0xA5, DONE=1, BUSY=0.
- 16-byte transfer with TX[i]=i·0x11, miso driven with 0x2AAA pattern bits, DIV=0: nss low 258 cycles, 128 sck edges, RX matches the serial model byte-for-byte.
- START re-written mid-transfer with LEN=5: ignored; the transfer completes with the original length and DIV.
- IRQ_EN=1: irq rises with DONE. DONE_CLR drops irq the next cycle. START with IRQ_EN=1 also clears irq from N+1.
- Reset pulse during byte 3 of 8: nss=1 and sck=0 while reset is high. After release: state IDLE, DONE=0, DIV=3.
- Read of 0x05 returns 0. Read of RX entry 0x10 returns 0x00A5 with 1-cycle latency.
